// File: rtl/icache_fill_arbiter.sv
// I-cache refill sequencer: arbitrates demand misses and next-line prefetches onto one L2 fill port,
// keeps a single fill in flight and assembles its beats into a full line for the cache write.
module icache_fill_arbiter #(
   parameter int PADDR_W = 40,
   parameter int LINE_W  = 512,
   parameter int BEAT_W  = 128,
   parameter int TMO_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               dmd_req_valid_i,
   input  logic [PADDR_W-1:0] dmd_req_paddr_i,
   output logic               dmd_req_ready_o,
   input  logic               pf_req_valid_i,
   input  logic [PADDR_W-1:0] pf_req_paddr_i,
   output logic               pf_req_ready_o,
   input  logic               flush_i,
   output logic               fill_req_valid_o,
   output logic [PADDR_W-1:0] fill_req_paddr_o,
   input  logic               fill_req_ready_i,
   input  logic               fill_resp_valid_i,
   input  logic [BEAT_W-1:0]  fill_resp_data_i,
   output logic               line_valid_o,
   output logic [LINE_W-1:0]  line_data_o,
   output logic [PADDR_W-1:0] line_paddr_o,
   output logic               line_is_pf_o,
   output logic               busy_o,
   output logic               timeout_o
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [PADDR_W-1:0] OFF_MASK  = PADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   function automatic logic [PADDR_W-1:0] line_addr(input logic [PADDR_W-1:0] a);
      return a & ~OFF_MASK;
   endfunction

   state_t             state_r;
   logic [PADDR_W-1:0] addr_r;
   logic               is_pf_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [TMO_W-1:0]   tmr_r;
   logic [LINE_W-1:0]  line_r;
   logic               timeout_r;

   logic [PADDR_W-1:0] dmd_line_s;
   logic               in_fill_s;
   logic               dmd_acc_s;
   logic               pf_acc_s;
   logic               promote_s;
   logic               last_beat_s;
   logic [TMO_W-1:0]   tmr_nxt_s;
   logic               tmo_hit_s;
   logic [LINE_W-1:0]  line_nxt_s;

   assign dmd_line_s  = line_addr(dmd_req_paddr_i);
   assign in_fill_s   = (state_r == S_REQ) || (state_r == S_WAIT) || (state_r == S_DONE);
   assign dmd_acc_s   = (state_r == S_IDLE) && dmd_req_valid_i && !flush_i && !rst_i;
   assign pf_acc_s    = (state_r == S_IDLE) && !dmd_req_valid_i && pf_req_valid_i && !flush_i && !rst_i;
   // A demand hitting the line already being prefetched rides on that fill instead of waiting.
   assign promote_s   = in_fill_s && is_pf_r && dmd_req_valid_i && (dmd_line_s == addr_r) && !flush_i && !rst_i;
   assign last_beat_s = (cnt_r == LAST_BEAT);
   assign tmr_nxt_s   = tmr_r + 1'b1;
   assign tmo_hit_s   = &tmr_nxt_s;

   assign dmd_req_ready_o  = dmd_acc_s || promote_s;
   assign pf_req_ready_o   = pf_acc_s;
   assign fill_req_valid_o = (state_r == S_REQ);
   assign fill_req_paddr_o = addr_r;
   assign line_valid_o     = (state_r == S_DONE) && !flush_i;
   assign line_data_o      = line_r;
   assign line_paddr_o     = addr_r;
   assign line_is_pf_o     = is_pf_r && !promote_s;
   assign busy_o           = (state_r != S_IDLE);
   assign timeout_o        = timeout_r;

   // Insert the incoming beat into its slot of the line buffer.
   always_comb begin
      line_nxt_s = line_r;
      for (int k = 0; k < BEATS; k++) begin
         if (cnt_r == CNT_W'(k)) begin
            line_nxt_s[k*BEAT_W +: BEAT_W] = fill_resp_data_i;
         end else begin
            line_nxt_s[k*BEAT_W +: BEAT_W] = line_r[k*BEAT_W +: BEAT_W];
         end
      end
   end

   // Fill sequencer state, line buffer, beat counter and response timer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= S_IDLE;
         addr_r    <= {PADDR_W{1'b0}};
         is_pf_r   <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
         tmr_r     <= {TMO_W{1'b0}};
         line_r    <= {LINE_W{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         if (promote_s) begin
            is_pf_r <= 1'b0;
         end
         case (state_r)
            S_IDLE: begin
               if (dmd_acc_s) begin
                  addr_r  <= dmd_line_s;
                  is_pf_r <= 1'b0;
                  state_r <= S_REQ;
               end else if (pf_acc_s) begin
                  addr_r  <= line_addr(pf_req_paddr_i);
                  is_pf_r <= 1'b1;
                  state_r <= S_REQ;
               end
            end
            S_REQ: begin
               cnt_r <= {CNT_W{1'b0}};
               tmr_r <= {TMO_W{1'b0}};
               if (flush_i) begin
                  state_r <= fill_req_ready_i ? S_DRAIN : S_IDLE;
               end else if (fill_req_ready_i) begin
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (fill_resp_valid_i) begin
                  cnt_r <= cnt_r + 1'b1;
                  tmr_r <= {TMO_W{1'b0}};
                  if (flush_i) begin
                     // A killed fill whose final beat lands now has nothing left to drain.
                     state_r <= last_beat_s ? S_IDLE : S_DRAIN;
                  end else begin
                     line_r <= line_nxt_s;
                     if (last_beat_s) begin
                        state_r <= S_DONE;
                     end
                  end
               end else if (flush_i) begin
                  tmr_r   <= {TMO_W{1'b0}};
                  state_r <= S_DRAIN;
               end else if (tmo_hit_s) begin
                  timeout_r <= 1'b1;
                  state_r   <= S_IDLE;
               end else begin
                  tmr_r <= tmr_nxt_s;
               end
            end
            S_DONE: begin
               state_r <= S_IDLE;
            end
            S_DRAIN: begin
               if (fill_resp_valid_i) begin
                  cnt_r <= cnt_r + 1'b1;
                  tmr_r <= {TMO_W{1'b0}};
                  if (last_beat_s) begin
                     state_r <= S_IDLE;
                  end
               end else if (tmo_hit_s) begin
                  timeout_r <= 1'b1;
                  state_r   <= S_IDLE;
               end else begin
                  tmr_r <= tmr_nxt_s;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_icache_fill_arbiter.sv
// Bench for icache_fill_arbiter: directed table of requests, multi-cycle corner sequences,
// and randomized fills checked against a transaction-level expectation.
module tb_icache_fill_arbiter;
   logic         clk = 1'b0;
   logic         rst;
   logic         dmd_req_valid;
   logic [39:0]  dmd_req_paddr;
   logic         dmd_req_ready_o;
   logic         pf_req_valid;
   logic [39:0]  pf_req_paddr;
   logic         pf_req_ready_o;
   logic         flush;
   logic         fill_req_valid_o;
   logic [39:0]  fill_req_paddr_o;
   logic         fill_req_ready;
   logic         fill_resp_valid;
   logic [127:0] fill_resp_data;
   logic         line_valid_o;
   logic [511:0] line_data_o;
   logic [39:0]  line_paddr_o;
   logic         line_is_pf_o;
   logic         busy_o;
   logic         timeout_o;

   int n_cmp = 0;
   int n_err = 0;
   int lv_cnt = 0;
   int both_rdy = 0;
   logic [127:0] beat_a [4];

   icache_fill_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .dmd_req_valid_i(dmd_req_valid), .dmd_req_paddr_i(dmd_req_paddr), .dmd_req_ready_o(dmd_req_ready_o),
      .pf_req_valid_i(pf_req_valid), .pf_req_paddr_i(pf_req_paddr), .pf_req_ready_o(pf_req_ready_o),
      .flush_i(flush),
      .fill_req_valid_o(fill_req_valid_o), .fill_req_paddr_o(fill_req_paddr_o), .fill_req_ready_i(fill_req_ready),
      .fill_resp_valid_i(fill_resp_valid), .fill_resp_data_i(fill_resp_data),
      .line_valid_o(line_valid_o), .line_data_o(line_data_o), .line_paddr_o(line_paddr_o),
      .line_is_pf_o(line_is_pf_o), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Count line-write pulses and any cycle where both readies are high.
   always @(posedge clk) if (line_valid_o === 1'b1) lv_cnt <= lv_cnt + 1;
   always @(negedge clk) if (dmd_req_ready_o === 1'b1 && pf_req_ready_o === 1'b1) both_rdy <= both_rdy + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one complete fill from IDLE; late demand (lv/la) is offered in the first WAIT cycle.
   task automatic run_fill(input logic dv, input logic [39:0] da, input logic pv, input logic [39:0] pa,
                           input logic lv, input logic [39:0] la, input int rdly, input int gap,
                           output logic o_dr, output logic o_pr, output logic [39:0] o_rq, output logic o_lr,
                           output logic o_lv, output logic [511:0] o_line, output logic [39:0] o_lpa,
                           output logic o_ispf, output int o_pulses);
      int lv0;
      lv0 = lv_cnt;
      o_lr = 1'b0;
      dmd_req_valid = dv; dmd_req_paddr = da; pf_req_valid = pv; pf_req_paddr = pa;
      @(negedge clk);
      o_dr = dmd_req_ready_o; o_pr = pf_req_ready_o;
      tick();
      dmd_req_valid = 1'b0; pf_req_valid = 1'b0;
      repeat (rdly) tick();
      @(negedge clk);
      check("fill_req_valid", fill_req_valid_o, 1'b1);
      o_rq = fill_req_paddr_o;
      fill_req_ready = 1'b1;
      tick();
      fill_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g <= gap; g++) begin
            fill_resp_valid = (g == gap);
            fill_resp_data = beat_a[k];
            if (k == 0 && g == 0 && lv) begin
               dmd_req_valid = 1'b1; dmd_req_paddr = la;
            end
            @(negedge clk);
            if (k == 0 && g == 0 && lv) o_lr = dmd_req_ready_o;
            tick();
            dmd_req_valid = 1'b0; fill_resp_valid = 1'b0;
         end
      end
      @(negedge clk);
      o_lv = line_valid_o; o_line = line_data_o; o_lpa = line_paddr_o; o_ispf = line_is_pf_o;
      tick();
      o_pulses = lv_cnt - lv0;
   endtask

   typedef struct {
      logic        dv;
      logic [39:0] da;
      logic        pv;
      logic [39:0] pa;
      int          rdly;
      int          gap;
      logic        e_dr;
      logic        e_pr;
      logic [39:0] e_addr;
      logic        e_ispf;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic r_dr, r_pr, r_lr, r_lv, r_ispf;
      logic [39:0] r_rq, r_lpa, wa, la, da, pa, exp_addr;
      logic [511:0] r_line, exp_line;
      logic [63:0] rnd;
      logic [31:0] w;
      logic dv, pv, lv, win_pf, exp_lr;
      int r_pulses, lv0, kind;

      tbl[0] = '{1'b1, 40'h0080001234, 1'b0, 40'h0,          0, 0, 1'b1, 1'b0, 40'h0080001200, 1'b0};
      tbl[1] = '{1'b1, 40'h00ABCDEF7F, 1'b1, 40'h0000001040, 1, 1, 1'b1, 1'b0, 40'h00ABCDEF40, 1'b0};
      tbl[2] = '{1'b0, 40'h0,          1'b1, 40'h0000001040, 2, 0, 1'b0, 1'b1, 40'h0000001040, 1'b1};
      tbl[3] = '{1'b1, 40'hFFFFFFFFFF, 1'b0, 40'h0,          0, 2, 1'b1, 1'b0, 40'hFFFFFFFFC0, 1'b0};
      tbl[4] = '{1'b0, 40'h0,          1'b1, 40'h000000003F, 3, 1, 1'b0, 1'b1, 40'h0000000000, 1'b1};

      rst = 1'b1; dmd_req_valid = 1'b0; dmd_req_paddr = 40'h0; pf_req_valid = 1'b0; pf_req_paddr = 40'h0;
      flush = 1'b0; fill_req_ready = 1'b0; fill_resp_valid = 1'b0; fill_resp_data = 128'h0;
      #3;
      check("rst_busy", busy_o, 1'b0);
      check("rst_timeout", timeout_o, 1'b0);
      check("rst_fill_req_valid", fill_req_valid_o, 1'b0);
      check("rst_line_valid", line_valid_o, 1'b0);
      check("rst_line_is_pf", line_is_pf_o, 1'b0);
      check("rst_line_data", line_data_o, 512'h0);
      check("rst_fill_paddr", fill_req_paddr_o, 40'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Directed request table.
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) begin
            w = 32'hA5000000 + 32'(i * 256 + k);
            beat_a[k] = {4{w}};
         end
         exp_line = {beat_a[3], beat_a[2], beat_a[1], beat_a[0]};
         run_fill(tbl[i].dv, tbl[i].da, tbl[i].pv, tbl[i].pa, 1'b0, 40'h0, tbl[i].rdly, tbl[i].gap,
                  r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
         check($sformatf("tbl%0d_dmd_ready", i), r_dr, tbl[i].e_dr);
         check($sformatf("tbl%0d_pf_ready", i), r_pr, tbl[i].e_pr);
         check($sformatf("tbl%0d_fill_paddr", i), r_rq, tbl[i].e_addr);
         check($sformatf("tbl%0d_line_valid", i), r_lv, 1'b1);
         check($sformatf("tbl%0d_line_data", i), r_line, exp_line);
         check($sformatf("tbl%0d_line_paddr", i), r_lpa, tbl[i].e_addr);
         check($sformatf("tbl%0d_is_pf", i), r_ispf, tbl[i].e_ispf);
         check($sformatf("tbl%0d_pulses", i), r_pulses, 1);
         @(negedge clk);
         check($sformatf("tbl%0d_idle_after", i), busy_o, 1'b0);
         tick();
      end

      // Promotion: prefetch 0x1040 then same-line demand 0x1058 during WAIT.
      for (int k = 0; k < 4; k++) beat_a[k] = {4{32'h11110000 + 32'(k)}};
      exp_line = {beat_a[3], beat_a[2], beat_a[1], beat_a[0]};
      run_fill(1'b0, 40'h0, 1'b1, 40'h1040, 1'b1, 40'h1058, 0, 1,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("promo_dmd_ready", r_lr, 1'b1);
      check("promo_is_pf", r_ispf, 1'b0);
      check("promo_line", r_line, exp_line);
      // Different-line demand during a prefetch fill must wait.
      run_fill(1'b0, 40'h0, 1'b1, 40'h1040, 1'b1, 40'h2000, 1, 0,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("nopromo_dmd_ready", r_lr, 1'b0);
      check("nopromo_is_pf", r_ispf, 1'b1);
      run_fill(1'b1, 40'h2000, 1'b0, 40'h0, 1'b0, 40'h0, 0, 0,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("after_nopromo_addr", r_lpa, 40'h2000);
      check("after_nopromo_ready", r_dr, 1'b1);

      // Flush after two beats: drain the rest, no line write.
      lv0 = lv_cnt;
      dmd_req_valid = 1'b1; dmd_req_paddr = 40'h3000;
      tick();
      dmd_req_valid = 1'b0; fill_req_ready = 1'b1;
      tick();
      fill_req_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         fill_resp_valid = 1'b1; fill_resp_data = 128'hDEAD;
         tick();
      end
      fill_resp_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; dmd_req_valid = 1'b1; dmd_req_paddr = 40'h5000;
      @(negedge clk);
      check("drain_busy", busy_o, 1'b1);
      check("drain_dmd_ready", dmd_req_ready_o, 1'b0);
      tick();
      dmd_req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         fill_resp_valid = 1'b1; fill_resp_data = 128'hBEEF;
         tick();
      end
      fill_resp_valid = 1'b0;
      @(negedge clk);
      check("drain_idle", busy_o, 1'b0);
      check("drain_no_line", lv_cnt - lv0, 0);
      tick();
      for (int k = 0; k < 4; k++) beat_a[k] = {4{32'h55550000 + 32'(k)}};
      exp_line = {beat_a[3], beat_a[2], beat_a[1], beat_a[0]};
      run_fill(1'b1, 40'h5000, 1'b0, 40'h0, 1'b0, 40'h0, 0, 0,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("post_flush_line", r_line, exp_line);
      check("post_flush_pulses", r_pulses, 1);

      // Response timeout after 255 idle cycles in WAIT.
      lv0 = lv_cnt;
      dmd_req_valid = 1'b1; dmd_req_paddr = 40'h4000;
      tick();
      dmd_req_valid = 1'b0; fill_req_ready = 1'b1;
      tick();
      fill_req_ready = 1'b0;
      repeat (254) tick();
      @(negedge clk);
      check("tmo_pre_busy", busy_o, 1'b1);
      check("tmo_pre_flag", timeout_o, 1'b0);
      tick();
      @(negedge clk);
      check("tmo_flag", timeout_o, 1'b1);
      check("tmo_idle", busy_o, 1'b0);
      check("tmo_no_line", lv_cnt - lv0, 0);
      tick();
      run_fill(1'b1, 40'h4100, 1'b0, 40'h0, 1'b0, 40'h0, 0, 0,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("tmo_sticky", timeout_o, 1'b1);
      check("tmo_next_line", r_line, exp_line);

      // Asynchronous reset mid-WAIT.
      dmd_req_valid = 1'b1; dmd_req_paddr = 40'h6000;
      tick();
      dmd_req_valid = 1'b0; fill_req_ready = 1'b1;
      tick();
      fill_req_ready = 1'b0; fill_resp_valid = 1'b1; fill_resp_data = 128'h1234;
      tick();
      fill_resp_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_busy", busy_o, 1'b0);
      check("arst_timeout", timeout_o, 1'b0);
      check("arst_line_data", line_data_o, 512'h0);
      check("arst_fill_valid", fill_req_valid_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) beat_a[k] = {4{32'h66660000 + 32'(k)}};
      exp_line = {beat_a[3], beat_a[2], beat_a[1], beat_a[0]};
      run_fill(1'b1, 40'h6000, 1'b0, 40'h0, 1'b0, 40'h0, 0, 0,
               r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
      check("arst_next_line", r_line, exp_line);
      check("arst_next_addr", r_lpa, 40'h6000);

      // Randomized fills against a transaction-level expectation.
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 2);
         dv = (kind != 1); pv = (kind != 0);
         rnd = {$urandom, $urandom}; da = rnd[39:0];
         rnd = {$urandom, $urandom}; pa = rnd[39:0];
         win_pf = !dv;
         wa = dv ? da : pa;
         exp_addr = wa & ~40'h3F;
         lv = 1'($urandom_range(0, 1));
         rnd = {$urandom, $urandom};
         la = ($urandom_range(0, 1) == 1) ? (exp_addr | {34'h0, rnd[5:0]}) : rnd[39:0];
         exp_lr = lv && win_pf && ((la & ~40'h3F) == exp_addr);
         for (int k = 0; k < 4; k++) beat_a[k] = {$urandom, $urandom, $urandom, $urandom};
         exp_line = {beat_a[3], beat_a[2], beat_a[1], beat_a[0]};
         run_fill(dv, da, pv, pa, lv, la, $urandom_range(0, 3), $urandom_range(0, 2),
                  r_dr, r_pr, r_rq, r_lr, r_lv, r_line, r_lpa, r_ispf, r_pulses);
         check($sformatf("rnd%0d_dmd_ready", it), r_dr, dv);
         check($sformatf("rnd%0d_pf_ready", it), r_pr, win_pf);
         check($sformatf("rnd%0d_fill_paddr", it), r_rq, exp_addr);
         check($sformatf("rnd%0d_late_ready", it), r_lr, exp_lr);
         check($sformatf("rnd%0d_line", it), r_line, exp_line);
         check($sformatf("rnd%0d_line_paddr", it), r_lpa, exp_addr);
         check($sformatf("rnd%0d_is_pf", it), r_ispf, win_pf && !exp_lr);
         check($sformatf("rnd%0d_pulses", it), r_pulses, 1);
      end

      check("never_both_ready", both_rdy, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
